// File: rtl/ram_burst_ctrl.sv
// Burst controller in front of the single-port synchronous RAM: sequences cs/rd/wr
// strobes and addresses for read/write bursts and returns read data as a registered stream.
module ram_burst_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wvalid,
  output logic              wready,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_dout,
  output logic              ram_oe,
  input  logic [DATA_W-1:0] ram_din,
  output logic              ram_cs,
  output logic              ram_rd,
  output logic              ram_wr
);

  typedef enum logic [1:0] {IDLE, WR, RD, RD_DRAIN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic [LEN_W-1:0]  len, len_nxt;
  logic [LEN_W-1:0]  cnt, cnt_nxt;
  logic [ADDR_W-1:0] ram_addr_nxt;
  logic [DATA_W-1:0] ram_dout_nxt;
  logic [DATA_W-1:0] rdata_nxt;
  logic              ram_cs_nxt, ram_rd_nxt, ram_wr_nxt;
  logic              rvalid_nxt, done_nxt;

  assign req_ready = (state == IDLE) && !rst;
  assign wready    = (state == WR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      addr     <= '0;
      len      <= '0;
      cnt      <= '0;
      ram_addr <= '0;
      ram_dout <= '0;
      ram_cs   <= 1'b0;
      ram_rd   <= 1'b0;
      ram_wr   <= 1'b0;
      ram_oe   <= 1'b0;
      rdata    <= '0;
      rvalid   <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      addr     <= addr_nxt;
      len      <= len_nxt;
      cnt      <= cnt_nxt;
      ram_addr <= ram_addr_nxt;
      ram_dout <= ram_dout_nxt;
      ram_cs   <= ram_cs_nxt;
      ram_rd   <= ram_rd_nxt;
      ram_wr   <= ram_wr_nxt;
      ram_oe   <= ram_wr_nxt;
      rdata    <= rdata_nxt;
      rvalid   <= rvalid_nxt;
      done     <= done_nxt;
    end
  end

  // addr holds the next address to issue; cnt is the index of the beat in flight.
  always_comb begin
    state_nxt    = state;
    addr_nxt     = addr;
    len_nxt      = len;
    cnt_nxt      = cnt;
    ram_addr_nxt = ram_addr;
    ram_dout_nxt = ram_dout;
    ram_cs_nxt   = 1'b0;
    ram_rd_nxt   = 1'b0;
    ram_wr_nxt   = 1'b0;
    done_nxt     = 1'b0;
    rdata_nxt    = rdata;
    rvalid_nxt   = 1'b0;

    // RAM output lags one cycle, so the first rd cycle has nothing to capture yet.
    if (ram_rd && !(state == RD && cnt == '0)) begin
      rdata_nxt  = ram_din;
      rvalid_nxt = 1'b1;
    end

    case (state)
      IDLE: begin
        if (req_valid) begin
          len_nxt = req_len;
          cnt_nxt = '0;
          if (req_we) begin
            state_nxt = WR;
            addr_nxt  = req_addr;
          end else begin
            state_nxt    = RD;
            ram_addr_nxt = req_addr;
            addr_nxt     = req_addr + ADDR_W'(1);
            ram_cs_nxt   = 1'b1;
            ram_rd_nxt   = 1'b1;
          end
        end
      end
      WR: begin
        if (wvalid) begin
          ram_cs_nxt   = 1'b1;
          ram_wr_nxt   = 1'b1;
          ram_addr_nxt = addr;
          ram_dout_nxt = wdata;
          addr_nxt     = addr + ADDR_W'(1);
          cnt_nxt      = cnt + LEN_W'(1);
          if (cnt == len) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      RD: begin
        ram_cs_nxt = 1'b1;
        ram_rd_nxt = 1'b1;
        if (cnt == len) begin
          state_nxt = RD_DRAIN;
        end else begin
          ram_addr_nxt = addr;
          addr_nxt     = addr + ADDR_W'(1);
          cnt_nxt      = cnt + LEN_W'(1);
        end
      end
      RD_DRAIN: begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Scoreboard bench for ram_burst_ctrl with a behavioural single-port RAM attached.
module tb_ram_burst_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready, req_we;
  logic [9:0] req_addr;
  logic [3:0] req_len;
  logic [7:0] wdata;
  logic       wvalid, wready;
  logic [7:0] rdata;
  logic       rvalid, done;
  logic [9:0] ram_addr;
  logic [7:0] ram_dout, ram_din;
  logic       ram_oe, ram_cs, ram_rd, ram_wr;

  typedef struct {
    logic [9:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t        wq[$];
  logic [7:0] rq[$];
  logic [7:0] mem [1024];
  logic [7:0] ref_mem [1024];
  logic [7:0] ram_q;
  int         vectors = 0;
  int         miscompares = 0;

  always #5 clk = ~clk;

  ram_burst_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_len(req_len),
    .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .rdata(rdata), .rvalid(rvalid), .done(done),
    .ram_addr(ram_addr), .ram_dout(ram_dout), .ram_oe(ram_oe), .ram_din(ram_din),
    .ram_cs(ram_cs), .ram_rd(ram_rd), .ram_wr(ram_wr)
  );

  // Behavioural RAM: registered read data, write from the controller's bus drive.
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] <= 8'(i * 37 + 5);
  end

  always @(posedge clk) begin
    if (ram_cs && ram_wr && ram_oe) mem[ram_addr] <= ram_dout;
    if (ram_cs && ram_rd) ram_q <= mem[ram_addr];
  end

  assign ram_din = ram_q;

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk);
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if ({ram_cs, ram_rd, ram_wr, ram_oe, rvalid, done, wready, req_ready} !== 8'h00 ||
          ram_addr !== 10'h000 || ram_dout !== 8'h00 || rdata !== 8'h00) begin
        miscompares++;
        $display("[TB] FAIL reset_outputs: got ctl=%b addr=%h dout=%h rdata=%h, expected all zero",
                 {ram_cs, ram_rd, ram_wr, ram_oe, rvalid, done, wready, req_ready},
                 ram_addr, ram_dout, rdata);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1 || ram_cs !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_release: got req_ready=%b cs=%b, expected 1 0", req_ready, ram_cs);
    end
  endtask

  // Write burst with wvalid dropped for gap_cycles cycles before beat gap_at.
  task automatic do_write(input logic [9:0] base, input logic [3:0] len,
                          input int gap_at, input int gap_cycles, input logic [7:0] seed);
    int   n = int'(len);
    int   beat = 0;
    int   gap_left = gap_cycles;
    int   guard = 0;
    logic prev_v = 1'b0, prev_last = 1'b0, cur_v, cur_last;
    logic [9:0] a;
    wr_t  e;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = base; req_len = len; wvalid = 1'b0;
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL wr_accept: got req_ready=%b, expected 1", req_ready);
    end
    forever begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_addr  = 10'(~base);
      if (beat <= n && !(beat == gap_at && gap_left > 0)) begin
        a = base + 10'(beat);
        wvalid = 1'b1;
        wdata  = seed + 8'(beat);
        e.a = a; e.d = wdata;
        wq.push_back(e);
        ref_mem[a] = wdata;
        cur_v = 1'b1;
        cur_last = (beat == n);
        beat++;
      end else begin
        if (beat <= n) gap_left--;
        wvalid = 1'b0;
        wdata  = 8'($urandom);
        cur_v = 1'b0;
        cur_last = 1'b0;
      end
      @(negedge clk);
      vectors++;
      if ({ram_cs, ram_wr, ram_oe, ram_rd, done, wready} !==
          {prev_v, prev_v, prev_v, 1'b0, prev_last, !prev_last}) begin
        miscompares++;
        $display("[TB] FAIL wr_strobes: got cs/wr/oe/rd/done/wready=%b, expected %b",
                 {ram_cs, ram_wr, ram_oe, ram_rd, done, wready},
                 {prev_v, prev_v, prev_v, 1'b0, prev_last, !prev_last});
      end
      if (prev_v) begin
        vectors++;
        if (wq.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL wr_queue: got strobe with empty queue, expected queued beat");
        end else begin
          e = wq.pop_front();
          if (ram_addr !== e.a || ram_dout !== e.d) begin
            miscompares++;
            $display("[TB] FAIL wr_beat: got addr=%h data=%h, expected addr=%h data=%h",
                     ram_addr, ram_dout, e.a, e.d);
          end
        end
      end
      if (prev_last) break;
      prev_v = cur_v;
      prev_last = cur_last;
      guard++;
      if (guard > 64) begin
        vectors++; miscompares++;
        $display("[TB] FAIL wr_bound: got >64 cycles, expected burst end");
        break;
      end
    end
    wvalid = 1'b0;
    vectors++;
    if (wq.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL wr_leftover: got %0d unwritten beats, expected 0", wq.size());
      wq.delete();
    end
  endtask

  task automatic do_read(input logic [9:0] base, input logic [3:0] len);
    int         n = int'(len);
    logic [9:0] a;
    logic [6:0] exp_ctl;
    logic [7:0] d;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = base; req_len = len;
    for (int k = 0; k <= n; k++) begin
      a = base + 10'(k);
      rq.push_back(ref_mem[a]);
    end
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rd_accept: got req_ready=%b, expected 1", req_ready);
    end
    for (int c = 1; c <= n + 3; c++) begin
      @(posedge clk); #1;
      req_valid = (c < n + 3);
      req_we    = 1'b1;
      wvalid    = 1'b1;
      @(negedge clk);
      exp_ctl = {c <= n + 2, c <= n + 2, 1'b0, 1'b0, c >= 3, c == n + 3, c == n + 3};
      vectors++;
      if ({ram_cs, ram_rd, ram_wr, ram_oe, rvalid, done, req_ready} !== exp_ctl) begin
        miscompares++;
        $display("[TB] FAIL rd_ctl cycle %0d: got cs/rd/wr/oe/rvalid/done/ready=%b, expected %b",
                 c, {ram_cs, ram_rd, ram_wr, ram_oe, rvalid, done, req_ready}, exp_ctl);
      end
      if (c <= n + 2) begin
        a = base + 10'((c - 1 < n) ? c - 1 : n);
        vectors++;
        if (ram_addr !== a) begin
          miscompares++;
          $display("[TB] FAIL rd_addr cycle %0d: got %h, expected %h", c, ram_addr, a);
        end
      end
      if (rvalid === 1'b1) begin
        vectors++;
        if (rq.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL rd_queue: got rvalid with empty queue, expected no beat");
        end else begin
          d = rq.pop_front();
          if (rdata !== d) begin
            miscompares++;
            $display("[TB] FAIL rd_data cycle %0d: got %h, expected %h", c, rdata, d);
          end
        end
      end
    end
    req_valid = 1'b0;
    wvalid = 1'b0;
    vectors++;
    if (rq.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL rd_leftover: got %0d missing beats, expected 0", rq.size());
      rq.delete();
    end
  endtask

  task automatic test_write_burst();
    do_write(10'h010, 4'd3, -1, 0, 8'hA1);
  endtask

  task automatic test_write_gap();
    do_write(10'h100, 4'd4, 2, 2, 8'h51);
  endtask

  task automatic test_read_burst();
    do_read(10'h010, 4'd3);
  endtask

  task automatic test_read_wrap();
    do_read(10'h3FE, 4'd2);
    do_read(10'h100, 4'd4);
  endtask

  task automatic test_reset_mid_burst();
    logic seen = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 10'h020; req_len = 4'd7;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({ram_cs, ram_rd, ram_wr, ram_oe, rvalid, done} !== 6'b0 || ram_addr !== 10'h000 ||
        req_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL mid_reset: got ctl=%b addr=%h ready=%b, expected 000000 000 1",
               {ram_cs, ram_rd, ram_wr, ram_oe, rvalid, done}, ram_addr, req_ready);
    end
    repeat (10) begin
      @(negedge clk);
      if (done || rvalid || ram_cs) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL mid_reset_quiet: got activity=%b, expected 0", seen);
    end
    do_read(10'h012, 4'd1);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_len = '0;
    wdata = '0; wvalid = 1'b0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'(i * 37 + 5);
    test_reset();
    test_write_burst();
    test_write_gap();
    test_read_burst();
    test_read_wrap();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
